// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding,
// the last-grant marker used for round-robin, and the default bus widths.
package mem_arbiter_pkg;

    // Default widths: word address bits [19:1] and a 16-bit data bus.
    localparam int unsigned ADDR_WIDTH_DEF = 19;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // The master that should win a lock-free contention, given who was served last.
    function automatic grant_t other_grant(input grant_t g);
        return (g == GRANT_D) ? GRANT_I : GRANT_D;
    endfunction

    // Grant state that serves a given master.
    function automatic arb_state_t grant_state(input grant_t g);
        return (g == GRANT_D) ? GRANT_DATA : GRANT_INSTR;
    endfunction

endpackage

// File: rtl/mem_arbiter_mux.sv
// Grant-to-bus steering for the memory arbiter. Purely combinational:
// the registered grant state selects which master drives the slave port,
// and the slave ack is returned only to the master that owns the bus.
module mem_arbiter_mux
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  arb_state_t                    state,
    // instruction fetch master
    input  logic [ADDR_WIDTH-1:0]         instr_m_addr,
    output logic [DATA_WIDTH-1:0]         instr_m_data_in,
    output logic                          instr_m_ack,
    // data master
    input  logic [ADDR_WIDTH-1:0]         data_m_addr,
    input  logic [DATA_WIDTH-1:0]         data_m_data_out,
    input  logic                          data_m_wr_en,
    input  logic [DATA_WIDTH/8-1:0]       data_m_bytesel,
    output logic [DATA_WIDTH-1:0]         data_m_data_in,
    output logic                          data_m_ack,
    // slave port
    output logic [ADDR_WIDTH-1:0]         q_m_addr,
    input  logic [DATA_WIDTH-1:0]         q_m_data_in,
    output logic [DATA_WIDTH-1:0]         q_m_data_out,
    output logic                          q_m_access,
    input  logic                          q_m_ack,
    output logic                          q_m_wr_en,
    output logic [DATA_WIDTH/8-1:0]       q_m_bytesel
);

    // Read data needs no gating: a master only looks at it while its ack is high.
    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

    // Drive the slave from the granted master; IDLE parks the bus at all-zero.
    // The grant is held (access stays high) until the slave acks, even if the
    // master misbehaves and drops its request early.
    always_comb begin
        q_m_access   = 1'b0;
        q_m_wr_en    = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_bytesel  = '0;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (state)
            GRANT_INSTR: begin
                // Fetches are always full-word reads.
                q_m_access  = 1'b1;
                q_m_addr    = instr_m_addr;
                q_m_bytesel = '1;
                instr_m_ack = q_m_ack;
            end
            GRANT_DATA: begin
                q_m_access   = 1'b1;
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                data_m_ack   = q_m_ack;
            end
            default: begin
                // IDLE: nothing granted, stray slave acks are dropped here.
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter between the Core's instruction fetch
// and data buses and the board memory controller. Round-robin between the
// two masters, data wins while the Core holds lock.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no grant; arbitrate the requests seen this cycle
// GRANT_INSTR | slave port owned by the fetch bus until q_m_ack
// GRANT_DATA  | slave port owned by the data bus until q_m_ack
//
// last_grant_q remembers who was served most recently (GRANT_D out of reset,
// so the first contention goes to instr).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // instruction fetch master
    input  logic [ADDR_WIDTH-1:0]         instr_m_addr,
    output logic [DATA_WIDTH-1:0]         instr_m_data_in,
    input  logic                          instr_m_access,
    output logic                          instr_m_ack,
    // data master
    input  logic [ADDR_WIDTH-1:0]         data_m_addr,
    output logic [DATA_WIDTH-1:0]         data_m_data_in,
    input  logic [DATA_WIDTH-1:0]         data_m_data_out,
    input  logic                          data_m_access,
    output logic                          data_m_ack,
    input  logic                          data_m_wr_en,
    input  logic [DATA_WIDTH/8-1:0]       data_m_bytesel,
    input  logic                          lock,
    // slave port
    output logic [ADDR_WIDTH-1:0]         q_m_addr,
    input  logic [DATA_WIDTH-1:0]         q_m_data_in,
    output logic [DATA_WIDTH-1:0]         q_m_data_out,
    output logic                          q_m_access,
    input  logic                          q_m_ack,
    output logic                          q_m_wr_en,
    output logic [DATA_WIDTH/8-1:0]       q_m_bytesel
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;

    // Next-state and round-robin bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (instr_m_access && data_m_access) begin
                    if (lock) begin
                        state_d = GRANT_DATA;
                    end else begin
                        state_d = grant_state(other_grant(last_grant_q));
                    end
                end else if (instr_m_access) begin
                    state_d = GRANT_INSTR;
                end else if (data_m_access) begin
                    state_d = GRANT_DATA;
                end
            end
            GRANT_INSTR: begin
                // The acked master's access is still high this cycle; it is
                // the old request, so only the other master is considered.
                if (q_m_ack) begin
                    last_grant_d = GRANT_I;
                    state_d      = data_m_access ? GRANT_DATA : IDLE;
                end
            end
            GRANT_DATA: begin
                if (q_m_ack) begin
                    last_grant_d = GRANT_D;
                    if (lock && data_m_access) begin
                        // Under lock, drop to IDLE so a re-request from the
                        // data bus wins the next arbitration over instr.
                        state_d = IDLE;
                    end else begin
                        state_d = instr_m_access ? GRANT_INSTR : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and last-grant registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    mem_arbiter_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .state           (state_q),
        .instr_m_addr    (instr_m_addr),
        .instr_m_data_in (instr_m_data_in),
        .instr_m_ack     (instr_m_ack),
        .data_m_addr     (data_m_addr),
        .data_m_data_out (data_m_data_out),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_bytesel  (data_m_bytesel),
        .data_m_data_in  (data_m_data_in),
        .data_m_ack      (data_m_ack),
        .q_m_addr        (q_m_addr),
        .q_m_data_in     (q_m_data_in),
        .q_m_data_out    (q_m_data_out),
        .q_m_access      (q_m_access),
        .q_m_ack         (q_m_ack),
        .q_m_wr_en       (q_m_wr_en),
        .q_m_bytesel     (q_m_bytesel)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1ns later, and a bus-ownership model advances on
// the rising edge.
module tb_mem_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = DW / 8;
    localparam int BUSW = 2 + BW + AW + DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] instr_m_addr = '0;
    logic [DW-1:0] instr_m_data_in;
    logic          instr_m_access = 1'b0;
    logic          instr_m_ack;
    logic [AW-1:0] data_m_addr = '0;
    logic [DW-1:0] data_m_data_in;
    logic [DW-1:0] data_m_data_out = '0;
    logic          data_m_access = 1'b0;
    logic          data_m_ack;
    logic          data_m_wr_en = 1'b0;
    logic [BW-1:0] data_m_bytesel = '0;
    logic          lock = 1'b0;
    logic [AW-1:0] q_m_addr;
    logic [DW-1:0] q_m_data_in = '0;
    logic [DW-1:0] q_m_data_out;
    logic          q_m_access;
    logic          q_m_ack = 1'b0;
    logic          q_m_wr_en;
    logic [BW-1:0] q_m_bytesel;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr_m_addr    (instr_m_addr),
        .instr_m_data_in (instr_m_data_in),
        .instr_m_access  (instr_m_access),
        .instr_m_ack     (instr_m_ack),
        .data_m_addr     (data_m_addr),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_access   (data_m_access),
        .data_m_ack      (data_m_ack),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_bytesel  (data_m_bytesel),
        .lock            (lock),
        .q_m_addr        (q_m_addr),
        .q_m_data_in     (q_m_data_in),
        .q_m_data_out    (q_m_data_out),
        .q_m_access      (q_m_access),
        .q_m_ack         (q_m_ack),
        .q_m_wr_en       (q_m_wr_en),
        .q_m_bytesel     (q_m_bytesel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the slave port (-1 nobody, 0 instr, 1 data),
    // who was served last, and who was acked on the most recent edge.
    int m_owner = -1;
    int m_last  = 1;
    bit m_acked_i = 1'b0;
    bit m_acked_d = 1'b0;

    function automatic void model_step();
        m_acked_i = 1'b0;
        m_acked_d = 1'b0;
        if (m_owner == 0 && q_m_ack) begin
            m_acked_i = 1'b1;
            m_last    = 0;
            m_owner   = data_m_access ? 1 : -1;
        end else if (m_owner == 1 && q_m_ack) begin
            m_acked_d = 1'b1;
            m_last    = 1;
            if (lock && data_m_access) m_owner = -1;
            else                       m_owner = instr_m_access ? 0 : -1;
        end else if (m_owner == -1) begin
            if (instr_m_access && data_m_access) m_owner = lock ? 1 : 1 - m_last;
            else if (instr_m_access)             m_owner = 0;
            else if (data_m_access)              m_owner = 1;
        end
    endfunction

    function automatic logic [BUSW-1:0] exp_bus();
        if (m_owner == 0) return {1'b1, 1'b0, {BW{1'b1}}, instr_m_addr, {DW{1'b0}}};
        if (m_owner == 1) return {1'b1, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out};
        return '0;
    endfunction

    function automatic logic [1:0] exp_acks();
        return {(q_m_ack && m_owner == 0), (q_m_ack && m_owner == 1)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        instr_m_access = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
        lock = 1'b0; q_m_ack = 1'b0; q_m_data_in = '0;
        m_owner = -1; m_last = 1; m_acked_i = 1'b0; m_acked_d = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        instr_m_addr = 19'h0ABCD; data_m_addr = 19'h71234;
        instr_m_access = 1'b1; data_m_access = 1'b1; lock = 1'b0; q_m_ack = 1'b1;
        m_owner = -1; m_last = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({instr_m_ack, data_m_ack, q_m_access} !== 3'b000)
            $display("FAIL reset_outputs: got acks/access %b expected 000", {instr_m_ack, data_m_ack, q_m_access});
        else n_pass++;
        n_checks++;
        if (q_m_addr !== '0) $display("FAIL reset_addr: got %h expected 0", q_m_addr);
        else n_pass++;
        @(negedge clk);
        q_m_ack = 1'b0; reset_n = 1'b1; #1;
        n_checks++;
        if (q_m_access !== 1'b0) $display("FAIL release_no_grant_yet: got %b expected 0", q_m_access);
        else n_pass++;
        cycle();
        n_checks++;
        if ({q_m_access, q_m_addr} !== {1'b1, 19'h0ABCD})
            $display("FAIL first_grant_instr: got access %b addr %h expected 1 0abcd", q_m_access, q_m_addr);
        else n_pass++;
        n_checks++;
        if ({q_m_wr_en, q_m_bytesel, q_m_data_out} !== {1'b0, 2'b11, 16'h0000})
            $display("FAIL instr_fixed_fields: got %b %b %h expected 0 11 0000", q_m_wr_en, q_m_bytesel, q_m_data_out);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int pulses;
        logic [BUSW-1:0] eb;
        apply_reset();
        data_m_addr = 19'h12345; data_m_data_out = 16'hBEEF; data_m_bytesel = 2'b10;
        data_m_wr_en = 1'b1; data_m_access = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            q_m_ack = (k == 3);
            if (k == 4) begin data_m_access = 1'b0; data_m_wr_en = 1'b0; end
            #1;
            eb = (k >= 1 && k <= 3) ? {1'b1, 1'b1, 2'b10, 19'h12345, 16'hBEEF} : '0;
            n_checks++;
            if ({q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out} !== eb)
                $display("FAIL write_bus k=%0d: got %h expected %h", k,
                         {q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out}, eb);
            else n_pass++;
            n_checks++;
            if ({instr_m_ack, data_m_ack} !== {1'b0, (k == 3)})
                $display("FAIL write_acks k=%0d: got %b expected %b", k, {instr_m_ack, data_m_ack}, {1'b0, (k == 3)});
            else n_pass++;
            if (data_m_ack) pulses++;
            cycle();
        end
        q_m_ack = 1'b0;
        n_checks++;
        if (pulses !== 1) $display("FAIL write_ack_pulses: got %0d expected 1", pulses);
        else n_pass++;
    endtask

    task automatic test_alternate();
        apply_reset();
        instr_m_addr = 19'h00100; data_m_addr = 19'h40200;
        data_m_wr_en = 1'b0; data_m_bytesel = 2'b01;
        instr_m_access = 1'b1; data_m_access = 1'b1; lock = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            q_m_ack = 1'b1; #1;
            n_checks++;
            if (q_m_access !== 1'b1) $display("FAIL alt_no_bubble k=%0d: got %b expected 1", k, q_m_access);
            else n_pass++;
            n_checks++;
            if (q_m_addr !== ((k % 2 == 0) ? 19'h00100 : 19'h40200))
                $display("FAIL alt_addr k=%0d: got %h expected %h", k, q_m_addr, (k % 2 == 0) ? 19'h00100 : 19'h40200);
            else n_pass++;
            n_checks++;
            if ({instr_m_ack, data_m_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL alt_acks k=%0d: got %b expected %b", k, {instr_m_ack, data_m_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            else n_pass++;
            cycle();
        end
        q_m_ack = 1'b0;
    endtask

    task automatic test_lock();
        int n_i;
        int n_d;
        apply_reset();
        instr_m_addr = 19'h01111; data_m_addr = 19'h52222; data_m_bytesel = 2'b11;
        lock = 1'b1; instr_m_access = 1'b1; data_m_access = 1'b1;
        n_i = 0; n_d = 0;
        for (int k = 0; k < 12; k++) begin
            q_m_ack = (m_owner != -1); #1;
            n_checks++;
            if ({q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out} !== exp_bus())
                $display("FAIL lock_bus k=%0d: got %h expected %h", k,
                         {q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out}, exp_bus());
            else n_pass++;
            if (instr_m_ack) n_i++;
            if (data_m_ack)  n_d++;
            cycle();
        end
        q_m_ack = 1'b0;
        n_checks++;
        if ({n_i, n_d} !== {32'd0, 32'd6}) $display("FAIL lock_ack_counts: got instr %0d data %0d expected 0 6", n_i, n_d);
        else n_pass++;
        n_checks++;
        if (q_m_access !== 1'b0) $display("FAIL lock_idle_after_ack: got %b expected 0", q_m_access);
        else n_pass++;
        lock = 1'b0;
        cycle();
        n_checks++;
        if ({q_m_access, q_m_addr} !== {1'b1, 19'h01111})
            $display("FAIL unlock_instr_next: got access %b addr %h expected 1 01111", q_m_access, q_m_addr);
        else n_pass++;
        instr_m_access = 1'b0; data_m_access = 1'b0;
    endtask

    task automatic test_read_routing();
        apply_reset();
        instr_m_addr = 19'h03030; data_m_addr = 19'h60606;
        instr_m_access = 1'b1; data_m_access = 1'b1; lock = 1'b0;
        cycle();
        q_m_data_in = 16'hA5A5; q_m_ack = 1'b1; #1;
        n_checks++;
        if ({instr_m_ack, data_m_ack, instr_m_data_in} !== {2'b10, 16'hA5A5})
            $display("FAIL read_instr: got acks %b data %h expected 10 a5a5", {instr_m_ack, data_m_ack}, instr_m_data_in);
        else n_pass++;
        n_checks++;
        if (data_m_data_in !== 16'hA5A5) $display("FAIL read_broadcast: got %h expected a5a5", data_m_data_in);
        else n_pass++;
        cycle();
        q_m_data_in = 16'h5A5A; #1;
        n_checks++;
        if ({instr_m_ack, data_m_ack, data_m_data_in} !== {2'b01, 16'h5A5A})
            $display("FAIL read_data: got acks %b data %h expected 01 5a5a", {instr_m_ack, data_m_ack}, data_m_data_in);
        else n_pass++;
        cycle();
        q_m_ack = 1'b0; instr_m_access = 1'b0; data_m_access = 1'b0;
    endtask

    task automatic test_reset_abort();
        apply_reset();
        data_m_addr = 19'h7FFFF; data_m_data_out = 16'h1234; data_m_wr_en = 1'b1;
        data_m_bytesel = 2'b01; data_m_access = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (q_m_access !== 1'b1) $display("FAIL abort_pre_grant: got %b expected 1", q_m_access);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({q_m_access, q_m_addr} !== {1'b0, 19'h0})
            $display("FAIL abort_async_drop: got access %b addr %h expected 0 0", q_m_access, q_m_addr);
        else n_pass++;
        data_m_access = 1'b0; data_m_wr_en = 1'b0; q_m_ack = 1'b1; #1;
        n_checks++;
        if ({instr_m_ack, data_m_ack} !== 2'b00) $display("FAIL abort_no_ack_in_reset: got %b expected 00", {instr_m_ack, data_m_ack});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1; m_owner = -1; m_last = 1;
        for (int k = 0; k < 4; k++) begin
            q_m_ack = (k % 2 == 0); #1;
            n_checks++;
            if ({q_m_access, instr_m_ack, data_m_ack} !== 3'b000)
                $display("FAIL abort_idle k=%0d: got access/acks %b expected 000", k, {q_m_access, instr_m_ack, data_m_ack});
            else n_pass++;
            cycle();
        end
        q_m_ack = 1'b0;
    endtask

    task automatic test_random();
        int slave_cnt;
        apply_reset();
        slave_cnt = $urandom_range(0, 3);
        for (int k = 0; k < 400; k++) begin
            if (m_acked_i || !instr_m_access) begin
                instr_m_access = ($urandom_range(0, 2) != 0);
                instr_m_addr   = AW'($urandom);
            end
            if (m_acked_d || !data_m_access) begin
                data_m_access   = ($urandom_range(0, 2) != 0);
                data_m_addr     = AW'($urandom);
                data_m_data_out = DW'($urandom);
                data_m_wr_en    = $urandom_range(0, 1) == 1;
                data_m_bytesel  = BW'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 15) == 0) lock = ~lock;
            q_m_data_in = DW'($urandom);
            if (m_owner == -1)        q_m_ack = ($urandom_range(0, 1) == 1);
            else if (slave_cnt == 0)  q_m_ack = 1'b1;
            else begin q_m_ack = 1'b0; slave_cnt--; end
            #1;
            n_checks++;
            if ({q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out} !== exp_bus())
                $display("FAIL rand_bus k=%0d: got %h expected %h", k,
                         {q_m_access, q_m_wr_en, q_m_bytesel, q_m_addr, q_m_data_out}, exp_bus());
            else n_pass++;
            n_checks++;
            if ({instr_m_ack, data_m_ack} !== exp_acks())
                $display("FAIL rand_acks k=%0d: got %b expected %b", k, {instr_m_ack, data_m_ack}, exp_acks());
            else n_pass++;
            n_checks++;
            if ({instr_m_data_in, data_m_data_in} !== {q_m_data_in, q_m_data_in})
                $display("FAIL rand_rdata k=%0d: got %h %h expected %h", k, instr_m_data_in, data_m_data_in, q_m_data_in);
            else n_pass++;
            cycle();
            if (m_acked_i || m_acked_d) slave_cnt = $urandom_range(0, 3);
        end
        q_m_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_lock();
        test_read_routing();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that shares a single external memory port between the Core's instruction fetch bus (instr_m_*) and data bus (data_m_*). It sits between Core and the board memory controller in each FPGA top level, replacing the per-bus ack loopbacks. Grants are round-robin, with data priority while the Core holds lock. Requests are serialised and the slave's multi-cycle ack is routed back to the granted master.

## Interface
- ADDR_WIDTH, 19, word address width (address bits [19:1])
- DATA_WIDTH, 16, data width; byte-select width is DATA_WIDTH/8
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- instr_m_addr  in  ADDR_WIDTH  instruction fetch address
- instr_m_data_in  out  DATA_WIDTH  fetch read data
- instr_m_access  in  1  fetch request, held until ack
- instr_m_ack  out  1  fetch complete, one-cycle pulse
- data_m_addr  in  ADDR_WIDTH  data address
- data_m_data_in  out  DATA_WIDTH  data read data
- data_m_data_out  in  DATA_WIDTH  data write data
- data_m_access  in  1  data request, held until ack
- data_m_ack  out  1  data complete, one-cycle pulse
- data_m_wr_en  in  1  data write enable
- data_m_bytesel  in  2  data byte lanes
- lock  in  1  Core bus lock; data requests win arbitration while high
- q_m_addr  out  ADDR_WIDTH  slave address
- q_m_data_in  in  DATA_WIDTH  slave read data
- q_m_data_out  out  DATA_WIDTH  slave write data
- q_m_access  out  1  slave request
- q_m_ack  in  1  slave complete, one-cycle pulse
- q_m_wr_en  out  1  slave write enable
- q_m_bytesel  out  2  slave byte lanes

## Operation
- States: IDLE, GRANT_INSTR, GRANT_DATA. Registered 1-bit last_grant: 0 = instr, 1 = data.
- IDLE transitions:
  - Only one master requesting: grant that master.
  - Both requesting, lock=1: GRANT_DATA.
  - Both requesting, lock=0: grant the master not equal to last_grant.
- GRANT_x: q_m_* is driven combinationally from master x.
  - q_m_ack is routed to x_ack and updates last_grant.
- On q_m_ack in GRANT_x:
  - Next state is GRANT_other if the other master's access is high, else IDLE.
  - The acked master's still-high access that cycle is never treated as a new request.
  - Exception: GRANT_DATA with lock=1 and data_m_access high goes to IDLE. data then wins re-arbitration on the next cycle, provided it re-requests while lock is still high.
- No q_m_ack: stay in GRANT_x.
  - A master dropping access before ack violates protocol. The arbiter does not check for it; the grant is held until ack.
- IDLE outputs: q_m_access=0, q_m_wr_en=0, q_m_addr=0, q_m_data_out=0, q_m_bytesel=0.
- GRANT_INSTR outputs: q_m_wr_en=0, q_m_bytesel=2'b11, q_m_data_out=0.
- Read data: q_m_data_in is broadcast to both *_data_in; only the ack is gated.
- Reset values: state=IDLE, last_grant=1 (instr wins the first contention), all acks 0, all q_m_* 0.
  - Reset mid-transaction drops the grant immediately.
  - The slave shares reset_n and abandons its transaction.

## Timing
- A request seen in IDLE at cycle N makes q_m_access high in cycle N+1 (one registered arbitration cycle).
- Ack path is combinational, zero cycles: x_ack = q_m_ack & granted(x).
- Back-to-back alternation with no bubble: ack at cycle M, other master's q_m_access high at M+1.
- Same master re-requesting with no competitor: ack at M, IDLE at M+1, granted at M+2 (one bubble).
- Never more than one ack high per cycle. q_m_ack while IDLE is ignored.

## Structure
- Shared package mem_arbiter_pkg holds the state enum (IDLE, GRANT_INSTR, GRANT_DATA) and the grant_t typedef (GRANT_I, GRANT_D).
- One natural sub-module, mem_arbiter_mux: a purely combinational grant-to-bus mux for the q_m_* outputs and ack routing, parameterised by ADDR_WIDTH and DATA_WIDTH.
- FSM and last_grant stay in mem_arbiter.

## Test plan
- Reset: reset_n=0 with both accesses high -> all acks and q_m_access 0. Release -> instr granted first (q_m_addr=instr_m_addr) the cycle after release is seen.
- Single data write, addr 0x12345, data 0xBEEF, bytesel 2'b10, slave acks after 3 cycles:
  - q_m_* match from N+1.
  - data_m_ack pulses exactly once, in the slave's ack cycle.
  - instr_m_ack stays 0.
- Both requesting continuously, lock=0, 1-cycle slave -> grants strictly alternate I,D,I,D with no IDLE cycles between.
- Both requesting, lock=1, data re-requesting after each ack -> data granted every time; instr starves until lock drops, then is granted next.
- Read routing: slave returns 0xA5A5 on ack during GRANT_INSTR -> instr_m_data_in=0xA5A5 with instr_m_ack=1; data_m_ack=0.
- reset_n pulsed low mid-GRANT_DATA before ack -> q_m_access 0 asynchronously; no ack ever issued for the aborted access; IDLE after release.
